// File: rtl/control_unit_if.sv
// Bus between the control unit and its instruction ROM / datapath.
// The control unit connects through the master modport and the datapath side through the slave modport.
interface control_unit_if #(
   parameter int PC_W = 7,
   parameter int DA_W = 8,
   parameter int RA_W = 4
);
   logic [15:0]     InstrData;
   logic [PC_W-1:0] PC_Addr;
   logic [DA_W-1:0] D_Addr;
   logic            D_Wr;
   logic            RF_s;
   logic [RA_W-1:0] RF_W_Addr;
   logic            RF_W_en;
   logic [RA_W-1:0] RF_Ra_Addr;
   logic [RA_W-1:0] RF_Rb_Addr;
   logic [2:0]      ALU_s0;
   logic [3:0]      OutState;

   modport master (
      input  InstrData,
      output PC_Addr, D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_en,
             RF_Ra_Addr, RF_Rb_Addr, ALU_s0, OutState
   );

   modport slave (
      output InstrData,
      input  PC_Addr, D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_en,
             RF_Ra_Addr, RF_Rb_Addr, ALU_s0, OutState
   );
endinterface

// File: rtl/control_unit.sv
// Moore FSM sequencing fetch/decode/execute for a 16-bit instruction set.
// All datapath controls are decoded from the current state and the instruction register.
module control_unit #(
   parameter int PC_W = 7,
   parameter int DA_W = 8,
   parameter int RA_W = 4
) (
   input  logic          Clock,
   input  logic          Reset,
   control_unit_if.master bus
);

   typedef enum logic [3:0] {
      S_INIT   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_NOOP   = 4'd3,
      S_LOAD_A = 4'd4,
      S_LOAD_B = 4'd5,
      S_STORE  = 4'd6,
      S_ALU    = 4'd7,
      S_HALT   = 4'd8
   } state_e;

   state_e          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [15:0]     ir_q, ir_d;

   function automatic state_e decode_op(input logic [3:0] op);
      case (op)
         4'h1:                             return S_STORE;
         4'h2:                             return S_LOAD_A;
         4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: return S_ALU;
         4'hF:                             return S_HALT;
         default:                          return S_NOOP;
      endcase
   endfunction

   // Opcode to ALU Sel: arithmetic/logic ops skip the A-pass code 3, INC uses A+1.
   function automatic logic [2:0] alu_sel(input logic [3:0] op);
      case (op)
         4'h3:    return 3'd1;
         4'h4:    return 3'd2;
         4'h5:    return 3'd4;
         4'h6:    return 3'd5;
         4'h7:    return 3'd6;
         4'h8:    return 3'd7;
         default: return 3'd0;
      endcase
   endfunction

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= S_INIT;
         pc_q    <= '0;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      case (state_q)
         S_INIT:   state_d = S_FETCH;
         S_FETCH: begin
            state_d = S_DECODE;
            ir_d    = bus.InstrData;
            pc_d    = pc_q + PC_W'(1);
         end
         S_DECODE: state_d = decode_op(ir_q[15:12]);
         S_LOAD_A: state_d = S_LOAD_B;
         S_NOOP, S_LOAD_B, S_STORE, S_ALU: state_d = S_FETCH;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_INIT;
      endcase
   end

   assign bus.PC_Addr  = pc_q;
   assign bus.OutState = state_q;

   always_comb begin
      bus.D_Addr     = '0;
      bus.D_Wr       = 1'b0;
      bus.RF_s       = 1'b0;
      bus.RF_W_Addr  = '0;
      bus.RF_W_en    = 1'b0;
      bus.RF_Ra_Addr = '0;
      bus.RF_Rb_Addr = '0;
      bus.ALU_s0     = 3'd0;
      case (state_q)
         S_LOAD_A: begin
            bus.D_Addr = ir_q[DA_W-1:0];
            bus.RF_s   = 1'b1;
         end
         S_LOAD_B: begin
            bus.D_Addr    = ir_q[DA_W-1:0];
            bus.RF_s      = 1'b1;
            bus.RF_W_Addr = ir_q[8 +: RA_W];
            bus.RF_W_en   = 1'b1;
         end
         S_STORE: begin
            bus.D_Addr     = ir_q[DA_W-1:0];
            bus.RF_Ra_Addr = ir_q[8 +: RA_W];
            bus.D_Wr       = 1'b1;
         end
         S_ALU: begin
            bus.RF_Ra_Addr = ir_q[8 +: RA_W];
            bus.RF_Rb_Addr = ir_q[4 +: RA_W];
            bus.RF_W_Addr  = ir_q[0 +: RA_W];
            bus.RF_W_en    = 1'b1;
            bus.ALU_s0     = alu_sel(ir_q[15:12]);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: an instruction-level model queues the expected per-cycle
// outputs for each program, and they are compared each cycle against the DUT.
module tb_control_unit;
   localparam int PC_W = 7;
   localparam int DA_W = 8;
   localparam int RA_W = 4;

   typedef struct {
      logic [3:0] st;
      logic [6:0] pc;
      logic [7:0] da;
      logic       dwr;
      logic       rfs;
      logic [3:0] wa;
      logic       wen;
      logic [3:0] ra;
      logic [3:0] rb;
      logic [2:0] alu;
   } exp_t;

   logic Clock = 1'b0;
   logic Reset = 1'b1;
   logic [15:0] rom [0:127];
   exp_t exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   control_unit_if #(.PC_W(PC_W), .DA_W(DA_W), .RA_W(RA_W)) bus ();

   control_unit #(.PC_W(PC_W), .DA_W(DA_W), .RA_W(RA_W)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus.master)
   );

   always #5 Clock = ~Clock;

   // Registered instruction ROM, one cycle read latency.
   always @(posedge Clock) bus.InstrData <= rom[bus.PC_Addr];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic push_exp(input logic [3:0] st, input logic [6:0] pc, input logic [7:0] da,
                           input logic dwr, input logic rfs, input logic [3:0] wa, input logic wen,
                           input logic [3:0] ra, input logic [3:0] rb, input logic [2:0] alu);
      exp_t e;
      e.st = st; e.pc = pc; e.da = da; e.dwr = dwr; e.rfs = rfs;
      e.wa = wa; e.wen = wen; e.ra = ra; e.rb = rb; e.alu = alu;
      exp_q.push_back(e);
   endtask

   task automatic push_idle(input logic [3:0] st, input logic [6:0] pc);
      push_exp(st, pc, 8'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'd0);
   endtask

   function automatic logic [2:0] exp_alu(input logic [3:0] op);
      case (op)
         4'h3:    return 3'd1;
         4'h4:    return 3'd2;
         4'h5:    return 3'd4;
         4'h6:    return 3'd5;
         4'h7:    return 3'd6;
         4'h8:    return 3'd7;
         default: return 3'd0;
      endcase
   endfunction

   // Walks the program from PC 0 and queues the expected outputs of every cycle.
   task automatic model_program(input int n_instr, input int halt_hold);
      logic [6:0]  pc;
      logic [15:0] ins;
      logic [3:0]  op;
      bit          halted;
      pc = 7'd0;
      halted = 1'b0;
      push_idle(4'd0, pc);
      for (int i = 0; i < n_instr && !halted; i++) begin
         ins = rom[pc];
         op  = ins[15:12];
         push_idle(4'd1, pc);
         pc = pc + 7'd1;
         push_idle(4'd2, pc);
         case (op)
            4'h1: push_exp(4'd6, pc, ins[7:0], 1'b1, 1'b0, 4'd0, 1'b0, ins[11:8], 4'd0, 3'd0);
            4'h2: begin
               push_exp(4'd4, pc, ins[7:0], 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 4'd0, 3'd0);
               push_exp(4'd5, pc, ins[7:0], 1'b0, 1'b1, ins[11:8], 1'b1, 4'd0, 4'd0, 3'd0);
            end
            4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8:
               push_exp(4'd7, pc, 8'd0, 1'b0, 1'b0, ins[3:0], 1'b1, ins[11:8], ins[7:4], exp_alu(op));
            4'hF: begin
               for (int j = 0; j < halt_hold; j++) push_idle(4'd8, pc);
               halted = 1'b1;
            end
            default: push_idle(4'd3, pc);
         endcase
      end
   endtask

   task automatic compare(input string name, input int cyc, input exp_t e);
      string p;
      p = $sformatf("%s_c%0d", name, cyc);
      check_eq({p, "_state"}, 32'(bus.OutState),   32'(e.st));
      check_eq({p, "_pc"},    32'(bus.PC_Addr),    32'(e.pc));
      check_eq({p, "_daddr"}, 32'(bus.D_Addr),     32'(e.da));
      check_eq({p, "_dwr"},   32'(bus.D_Wr),       32'(e.dwr));
      check_eq({p, "_rfs"},   32'(bus.RF_s),       32'(e.rfs));
      check_eq({p, "_waddr"}, 32'(bus.RF_W_Addr),  32'(e.wa));
      check_eq({p, "_wen"},   32'(bus.RF_W_en),    32'(e.wen));
      check_eq({p, "_ra"},    32'(bus.RF_Ra_Addr), 32'(e.ra));
      check_eq({p, "_rb"},    32'(bus.RF_Rb_Addr), 32'(e.rb));
      check_eq({p, "_alu"},   32'(bus.ALU_s0),     32'(e.alu));
   endtask

   // Called at the negedge right after reset release; the first entry is the INIT cycle.
   task automatic run_sb(input string name);
      int   cyc;
      exp_t e;
      cyc = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         compare(name, cyc, e);
         cyc++;
         if (exp_q.size() > 0) @(negedge Clock);
      end
   endtask

   task automatic do_reset(input string name);
      exp_t e;
      @(negedge Clock);
      Reset = 1'b1;
      repeat (3) @(posedge Clock);
      @(negedge Clock);
      e = '{st: 4'd0, pc: 7'd0, da: 8'd0, dwr: 1'b0, rfs: 1'b0, wa: 4'd0,
            wen: 1'b0, ra: 4'd0, rb: 4'd0, alu: 3'd0};
      compare({name, "_rst"}, 0, e);
      Reset = 1'b0;
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      bit found;

      // Mixed program: every opcode class, ending in HALT held 20 cycles.
      clear_rom();
      rom[0]  = 16'h2305;
      rom[1]  = 16'h3124;
      rom[2]  = 16'h4124;
      rom[3]  = 16'h8104;
      rom[4]  = 16'h1207;
      rom[5]  = 16'h9ABC;
      rom[6]  = 16'h5F3A;
      rom[7]  = 16'h6012;
      rom[8]  = 16'h7345;
      rom[9]  = 16'h0000;
      rom[10] = 16'hF000;
      do_reset("mix");
      model_program(11, 20);
      run_sb("mix");

      // HALT at address 3 keeps PC at 4.
      clear_rom();
      rom[3] = 16'hF000;
      do_reset("halt");
      model_program(4, 20);
      run_sb("halt");

      // Reset asserted while D_Wr is high must kill the write at the next edge.
      clear_rom();
      rom[0] = 16'h1207;
      do_reset("rststore");
      found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
         @(negedge Clock);
         if (bus.OutState == 4'd6) found = 1'b1;
      end
      check_eq("reach_store", 32'(found), 32'd1);
      check_eq("store_dwr", 32'(bus.D_Wr), 32'd1);
      Reset = 1'b1;
      @(posedge Clock);
      #1;
      check_eq("rst_dwr",   32'(bus.D_Wr),     32'd0);
      check_eq("rst_state", 32'(bus.OutState), 32'd0);
      check_eq("rst_pc",    32'(bus.PC_Addr),  32'd0);
      check_eq("rst_wen",   32'(bus.RF_W_en),  32'd0);
      repeat (2) @(posedge Clock);
      #1;
      check_eq("rst_hold_state", 32'(bus.OutState), 32'd0);
      check_eq("rst_hold_dwr",   32'(bus.D_Wr),     32'd0);

      // All-NOOP program runs PC past 127 back to 0.
      clear_rom();
      do_reset("wrap");
      model_program(130, 0);
      run_sb("wrap");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
